dcache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache; one 32-bit word per line.

---
 rtl/dcache_nway_wb.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dcache_nway_wb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway_wb.sv
// dcache_nway_wb: N-way set-associative, write-back, write-allocate data cache.
// Each line holds one 32-bit word. The cache sits between the load/store unit
// and the memory controller.
//
// Optional feature macro: DCACHE_STATS_EN (adds hit_cnt_o / miss_cnt_o).
//
// Ports
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   cpu_req_i         request, accepted only while cpu_ready_o=1
//   cpu_we_i          1=store, 0=load
//   cpu_size_i        00=byte, 01=half, 10=word, 11=illegal
//   cpu_addr_i        byte address
//   cpu_wdata_i       store data, lane-aligned to cpu_addr_i[1:0]
//   cpu_ready_o       FSM idle, a request can be accepted
//   cpu_done_o        one-cycle pulse when the access completes
//   cpu_err_o         with cpu_done_o: misaligned or illegal size, no state change
//   cpu_rdata_o       full load word, valid with cpu_done_o
//   mem_req_o         memory request, held with the other mem_* outputs until mem_ack_i
//   mem_we_o          1=write-back, 0=refill
//   mem_addr_o        word-aligned memory address
//   mem_wdata_o       victim data on write-back
//   mem_ack_i         transfer complete; mem_rdata_i valid this cycle on refill
//   mem_rdata_i       refill data
//   hit_cnt_o, miss_cnt_o   (DCACHE_STATS_EN only) first-lookup hit/miss counters

// Tag compare for one way of the selected set.
module dcache_way_cmp #(
   parameter int TAG_W = 10
) (
   input  logic             valid_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             hit_o
);
   assign hit_o = valid_i && (tag_i == req_tag_i);
endmodule

module dcache_nway_wb #(
   parameter int WAYS   = 4,
   parameter int SETS   = 256,
   parameter int ADDR_W = 20
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [1:0]        cpu_size_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic              cpu_ready_o,
   output logic              cpu_done_o,
   output logic              cpu_err_o,
   output logic [31:0]       cpu_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 2 - IDX_W;
   localparam int AGE_W = $clog2(WAYS);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_DONE, S_WB, S_REFILL} state_t;
   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } req_t;

   state_t            state_q;
   req_t              req_q;
   logic [AGE_W-1:0]  vic_q;
   logic              replay_q, err_q;
   logic              cpu_ready_q, cpu_done_q, cpu_err_q;
   logic [31:0]       cpu_rdata_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   // Arrays indexed by set; the way dimension is packed so a whole set reads at once.
   logic [WAYS-1:0][31:0]       data_q  [SETS];
   logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
   logic [WAYS-1:0]             valid_q [SETS];
   logic [WAYS-1:0]             dirty_q [SETS];
   logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [WAYS-1:0]  way_hit;
   logic             hit, misalign;
   logic [AGE_W-1:0] hit_way, victim;
   logic [3:0]       be;
   logic [31:0]      old_word, merged;

   assign idx = req_q.addr[IDX_W+1:2];
   assign tag = req_q.addr[ADDR_W-1:IDX_W+2];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      dcache_way_cmp #(.TAG_W(TAG_W)) u_cmp (
         .valid_i   (valid_q[idx][g]),
         .tag_i     (tag_q[idx][g]),
         .req_tag_i (tag),
         .hit_o     (way_hit[g])
      );
   end

   assign misalign = (req_q.size == 2'b11) ||
                     (req_q.size == 2'b01 && req_q.addr[0]) ||
                     (req_q.size == 2'b10 && req_q.addr[1:0] != 2'b00);

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++)
         if (way_hit[w]) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      // Oldest way first, then let the lowest invalid way override it.
      victim = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (age_q[idx][w] == AGE_MAX) victim = AGE_W'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[idx][w]) victim = AGE_W'(w);
   end

   always_comb begin
      case (req_q.size)
         2'b00:   be = 4'b0001 << req_q.addr[1:0];
         2'b01:   be = 4'b0011 << req_q.addr[1:0];
         default: be = 4'b1111;
      endcase
      old_word = data_q[idx][hit_way];
      for (int b = 0; b < 4; b++)
         merged[8*b +: 8] = be[b] ? req_q.wdata[8*b +: 8] : old_word[8*b +: 8];
   end

   // Data/tag storage carries no reset; validity lives in the reset flops.
   always_ff @(posedge clk_i) begin
      if (state_q == S_LOOKUP && !misalign && hit && req_q.we)
         data_q[idx][hit_way] <= merged;
      else if (state_q == S_REFILL && mem_ack_i) begin
         data_q[idx][vic_q] <= mem_rdata_i;
         tag_q[idx][vic_q]  <= tag;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         req_q       <= '0;
         vic_q       <= '0;
         replay_q    <= 1'b0;
         err_q       <= 1'b0;
         cpu_ready_q <= 1'b1;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            age_q[s]   <= '0;
         end
`ifdef DCACHE_STATS_EN
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
`endif
      end else begin
         cpu_done_q <= 1'b0;
         cpu_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (cpu_req_i) begin
               req_q       <= '{cpu_we_i, cpu_size_i, cpu_addr_i, cpu_wdata_i};
               cpu_ready_q <= 1'b0;
               replay_q    <= 1'b0;
               state_q     <= S_LOOKUP;
            end
            S_LOOKUP: begin
               err_q <= misalign;
               if (misalign)
                  state_q <= S_DONE;
               else if (hit) begin
`ifdef DCACHE_STATS_EN
                  if (!replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
                  for (int w = 0; w < WAYS; w++)
                     if (age_q[idx][w] < age_q[idx][hit_way])
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                  age_q[idx][hit_way] <= '0;
                  if (req_q.we) dirty_q[idx][hit_way] <= 1'b1;
                  else          cpu_rdata_q <= old_word;
                  state_q <= S_DONE;
               end else begin
`ifdef DCACHE_STATS_EN
                  miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
                  vic_q     <= victim;
                  mem_req_q <= 1'b1;
                  if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= {tag_q[idx][victim], idx, 2'b00};
                     mem_wdata_q <= data_q[idx][victim];
                     state_q     <= S_WB;
                  end else begin
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {tag, idx, 2'b00};
                     state_q    <= S_REFILL;
                  end
               end
            end
            S_DONE: begin
               cpu_done_q  <= 1'b1;
               cpu_err_q   <= err_q;
               cpu_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            S_WB: if (mem_ack_i) begin
               mem_we_q   <= 1'b0;
               mem_addr_q <= {tag, idx, 2'b00};
               state_q    <= S_REFILL;
            end
            S_REFILL: if (mem_ack_i) begin
               mem_req_q             <= 1'b0;
               valid_q[idx][vic_q]   <= 1'b1;
               dirty_q[idx][vic_q]   <= 1'b0;
               // Install as oldest so the replay hit ranks every other way
               // (including still-invalid ones) one step older; this keeps
               // the ages of valid ways a strict recency order after reset.
               age_q[idx][vic_q]     <= AGE_MAX;
               replay_q              <= 1'b1;
               state_q               <= S_LOOKUP;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_ready_o = cpu_ready_q;
   assign cpu_done_o  = cpu_done_q;
   assign cpu_err_o   = cpu_err_q;
   assign cpu_rdata_o = cpu_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dcache_nway_wb.sv
// Bench for dcache_nway_wb (WAYS=4, SETS=256, ADDR_W=20). A reference cache
// model with timestamp LRU and its own copy of memory predicts every access.
module tb_dcache_nway_wb;
   localparam int AW = 20;

   logic          clk = 1'b0, rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [1:0]    cpu_size = 2'b00;
   logic [AW-1:0] cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic          cpu_ready, cpu_done, cpu_err;
   logic [31:0]   cpu_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack = 1'b0;
   logic [31:0]   mem_rdata = '0;
`ifdef DCACHE_STATS_EN
   logic [31:0]   hit_cnt, miss_cnt;
`endif

   dcache_nway_wb dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_size_i(cpu_size),
      .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_ready_o(cpu_ready), .cpu_done_o(cpu_done), .cpu_err_o(cpu_err),
      .cpu_rdata_o(cpu_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
`ifdef DCACHE_STATS_EN
      , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] data; } ev_t;
   ev_t act_ev[$], exp_ev[$];

   logic [31:0] bmem [logic [AW-1:0]];   // memory served to the DUT
   logic [31:0] rmem [logic [AW-1:0]];   // model's expectation of memory

   bit          m_vld   [256][4];
   bit          m_dirty [256][4];
   int          m_tag   [256][4];
   logic [31:0] m_data  [256][4];
   int          m_time  [256][4];
   int          tnow = 0;
   int          last_lat;
   logic [31:0] last_rd;

   function automatic logic [31:0] seed_val(input logic [AW-1:0] a);
      return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
   endfunction

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", nm, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 256; s++)
         for (int w = 0; w < 4; w++) begin
            m_vld[s][w] = 0; m_dirty[s][w] = 0; m_time[s][w] = 0;
         end
   endtask

   task automatic model(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                        input logic [31:0] wd, output logic er, output logic [31:0] rd,
                        output bit hit);
      int s, t, w, lane;
      logic [AW-1:0] wa;
      ev_t e;
      exp_ev.delete();
      rd = '0; hit = 0;
      er = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      if (er) return;
      s = int'(a[9:2]); t = int'(a[19:10]); wa = {a[19:2], 2'b00};
      w = -1;
      for (int i = 0; i < 4; i++) if (m_vld[s][i] && m_tag[s][i] == t) w = i;
      hit = (w >= 0);
      if (!hit) begin
         for (int i = 3; i >= 0; i--) if (!m_vld[s][i]) w = i;
         if (w < 0) begin
            w = 0;
            for (int i = 1; i < 4; i++) if (m_time[s][i] < m_time[s][w]) w = i;
         end
         if (m_vld[s][w] && m_dirty[s][w]) begin
            e.we = 1'b1; e.addr = AW'((m_tag[s][w] << 10) | (s << 2)); e.data = m_data[s][w];
            exp_ev.push_back(e);
            rmem[e.addr] = e.data;
         end
         e.we = 1'b0; e.addr = wa; e.data = '0;
         exp_ev.push_back(e);
         m_vld[s][w] = 1; m_dirty[s][w] = 0; m_tag[s][w] = t;
         m_data[s][w] = rmem.exists(wa) ? rmem[wa] : seed_val(wa);
      end
      tnow++;
      m_time[s][w] = tnow;
      if (we) begin
         for (int k = 0; k < (1 << sz); k++) begin
            lane = int'(a[1:0]) + k;
            m_data[s][w][8*lane +: 8] = wd[8*lane +: 8];
         end
         m_dirty[s][w] = 1;
      end else
         rd = m_data[s][w];
   endtask

   // Drives one request and plays the memory side until cpu_done.
   task automatic access(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
      int cyc, wcnt;
      bit pending;
      ev_t e;
      act_ev.delete();
      rd = '0; er = 1'b0; lat = -1; pending = 0; wcnt = 0;
      @(negedge clk);
      chk("ready_before_req", cpu_ready, 1'b1);
      cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      cyc = 0;
      while (cyc < 200) begin
         if (mem_ack) begin mem_ack = 1'b0; pending = 0; end
         if (cpu_done) begin rd = cpu_rdata; er = cpu_err; lat = cyc; break; end
         if (mem_req) begin
            if (!pending) begin
               pending = 1;
               e.we = mem_we; e.addr = mem_addr; e.data = mem_wdata;
               act_ev.push_back(e);
               wcnt = int'($urandom_range(0, 2));
            end else
               chk("mem_addr_held", mem_addr, act_ev[$].addr);
            if (wcnt == 0) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  bmem[mem_addr] = mem_wdata;
                  mem_rdata = $urandom;
               end else
                  mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : seed_val(mem_addr);
            end else
               wcnt--;
         end
         @(negedge clk);
         cyc++;
      end
      total++;
      assert (lat >= 0) else begin
         bad++;
         $error("FAIL access_timeout: got no cpu_done after %0d cycles, want done", cyc);
      end
   endtask

   task automatic run(input string nm, input logic we, input logic [1:0] sz,
                      input logic [AW-1:0] a, input logic [31:0] wd);
      logic er_e, er_a;
      logic [31:0] rd_e, rd_a;
      bit hit;
      int lat;
      model(we, sz, a, wd, er_e, rd_e, hit);
      access(we, sz, a, wd, rd_a, er_a, lat);
      chk({nm, ":err"}, 32'(er_a), 32'(er_e));
      if (!er_e && !we) chk({nm, ":rdata"}, rd_a, rd_e);
      if (hit || er_e) chk({nm, ":latency"}, lat, 2);
      chk({nm, ":mem_xfers"}, act_ev.size(), exp_ev.size());
      for (int i = 0; i < exp_ev.size() && i < act_ev.size(); i++) begin
         chk({nm, ":mem_we"}, 32'(act_ev[i].we), 32'(exp_ev[i].we));
         chk({nm, ":mem_addr"}, act_ev[i].addr, exp_ev[i].addr);
         if (exp_ev[i].we) chk({nm, ":mem_wdata"}, act_ev[i].data, exp_ev[i].data);
      end
      last_lat = lat;
      last_rd  = rd_a;
   endtask

   initial begin
      logic [1:0]    sz;
      logic [AW-1:0] a;
      int            r;

      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", cpu_ready, 1'b1);
      chk("rst_done", cpu_done, 1'b0);
      chk("rst_err", cpu_err, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);

      // Cold load, then the same load hits with no memory traffic.
      bmem[20'h00104] = 32'hCAFEBABE;
      rmem[20'h00104] = 32'hCAFEBABE;
      run("s1_cold", 1'b0, 2'b10, 20'h00104, 32'h0);
      chk("s1_cold_rdata", last_rd, 32'hCAFEBABE);
      if (act_ev.size() == 1) chk("s1_refill_addr", act_ev[0].addr, 32'h00104);
      run("s1_hit", 1'b0, 2'b10, 20'h00104, 32'h0);
      chk("s1_hit_latency", last_lat, 2);
      chk("s1_hit_no_mem", act_ev.size(), 0);
`ifdef DCACHE_STATS_EN
      chk("s6_miss_cnt", miss_cnt, 32'd1);
      chk("s6_hit_cnt", hit_cnt, 32'd1);
      @(negedge clk);
      force dut.hit_cnt_q = 32'hFFFFFFFF;
      #1 release dut.hit_cnt_q;
      run("s6_wrap_hit", 1'b0, 2'b10, 20'h00104, 32'h0);
      chk("s6_hit_wrap", hit_cnt, 32'h0);
      chk("s6_miss_same", miss_cnt, 32'd1);
`endif

      // Byte store merges into a cached word.
      run("s2_sw", 1'b1, 2'b10, 20'h00104, 32'h11223344);
      run("s2_sb", 1'b1, 2'b00, 20'h00105, 32'h0000AA00);
      chk("s2_sb_no_mem", act_ev.size(), 0);
      run("s2_lw", 1'b0, 2'b10, 20'h00104, 32'h0);
      chk("s2_merged", last_rd, 32'h1122AA44);

      // Fill set 0x41, make the dirty tag-0 line oldest, then force its eviction.
      for (int t = 1; t <= 3; t++) run("s3_fill", 1'b0, 2'b10, AW'((t << 10) | 'h104), 32'h0);
      for (int t = 1; t <= 3; t++) run("s3_touch", 1'b0, 2'b10, AW'((t << 10) | 'h104), 32'h0);
      run("s3_evict", 1'b0, 2'b10, 20'h01104, 32'h0);
      chk("s3_two_xfers", act_ev.size(), 2);
      if (act_ev.size() == 2) begin
         chk("s3_wb_first", 32'(act_ev[0].we), 32'd1);
         chk("s3_wb_addr", act_ev[0].addr, 32'h00104);
         chk("s3_wb_data", act_ev[0].data, 32'h1122AA44);
         chk("s3_refill_addr", act_ev[1].addr, 32'h01104);
      end

      // Misaligned half and illegal size: error, no memory traffic.
      run("s4_half_mis", 1'b0, 2'b01, 20'h00003, 32'h0);
      chk("s4_half_err", last_lat, 2);
      run("s4_size11", 1'b1, 2'b11, 20'h00408, 32'hDEADBEEF);
      chk("s4_size11_nomem", act_ev.size(), 0);

      // Random traffic over two sets and six tags to exercise replacement.
      for (int n = 0; n < 250; n++) begin
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         a  = AW'(($urandom_range(0, 5) << 10) | (($urandom_range(0, 1) != 0 ? 'h41 : 'h07) << 2)
                  | $urandom_range(0, 3));
         if ($urandom_range(0, 7) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         run("rnd", 1'($urandom_range(0, 1)), sz, a, $urandom);
      end

      // Reset during a refill aborts it; the line must miss again afterwards.
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 20'h0A008;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      chk("s5_in_refill", mem_req, 1'b1);
      chk("s5_refill_we", mem_we, 1'b0);
      rst = 1'b1;
      #1;
      chk("s5_mem_req_drop", mem_req, 1'b0);
      chk("s5_ready", cpu_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      // A stray ack while idle must be ignored.
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack_no_req", mem_req, 1'b0);
      chk("stray_ack_ready", cpu_ready, 1'b1);
      run("s5_reload", 1'b0, 2'b10, 20'h0A008, 32'h0);
      chk("s5_reload_miss", act_ev.size(), 1);
      run("post_rst_104", 1'b0, 2'b10, 20'h00104, 32'h0);
      chk("post_rst_104_miss", act_ev.size(), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
